vfifo_rd_fwft: RTL

First-word-fall-through read-side controller for the versatile FIFO, sitting directly downstream of the dual-port RAM's port B in the read clock domain. It owns the read pointer, drives the RAM read address, absorbs the RAM's one-cycle registered read latency, and presents a valid/ready stream with no bubbles at full rate. The write pointer arrives already synchronised into this domain. The read pointer is exported for fill-level and full logic on the write side.

---
 rtl/vfifo_pkg.sv | 21 ++
 rtl/vfifo_rd_fwft_if.sv | 28 ++
 rtl/vfifo_fwft_buf.sv | 54 +++++
 rtl/vfifo_rd_fwft.sv | 63 ++++++
 4 files changed

// File: rtl/vfifo_pkg.sv
// Shared constants and helpers for the versatile FIFO read side.
// Latency: none (definitions only). Backpressure: not applicable.
// FWFT_BUF_DEPTH sets the output skid depth that hides the RAM read latency.
package vfifo_pkg;

  localparam int FWFT_BUF_DEPTH = 2;
  localparam int FWFT_CNT_W     = $clog2(FWFT_BUF_DEPTH + 1);
  localparam int FWFT_IDX_W     = $clog2(FWFT_BUF_DEPTH);

  typedef logic [FWFT_CNT_W-1:0] fwft_cnt_t;
  typedef logic [FWFT_CNT_W:0]   fwft_occ_t;
  typedef logic [FWFT_IDX_W-1:0] fwft_idx_t;

  // Words committed to the buffer once this cycle's pop and in-flight read settle.
  function automatic fwft_occ_t fwft_committed(input fwft_cnt_t cnt,
                                               input logic      infl,
                                               input logic      pop);
    return {1'b0, cnt} + fwft_occ_t'(infl) - fwft_occ_t'(pop);
  endfunction

endpackage

// File: rtl/vfifo_rd_fwft_if.sv
// RAM port-B, pointer and output-stream signals of the FWFT read controller.
// Latency: none (wiring only). Backpressure: dout_ready from the consumer.
// master = the controller, slave = RAM/writer/consumer side.
interface vfifo_rd_fwft_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) ();

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] adr_b;
  logic [DATA_WIDTH-1:0] q_b;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  empty;

  modport master (
    input  wr_ptr, q_b, dout_ready,
    output rd_ptr, adr_b, dout, dout_valid, empty
  );

  modport slave (
    output wr_ptr, q_b, dout_ready,
    input  rd_ptr, adr_b, dout, dout_valid, empty
  );

endinterface

// File: rtl/vfifo_fwft_buf.sv
// Small in-order register queue that catches RAM read data for FWFT output.
// Latency: push visible at head the cycle after. Backpressure: caller must not push when full.
// Same-cycle push and pop keep cnt and advance the head.
module vfifo_fwft_buf
  import vfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output fwft_cnt_t             cnt
);

  logic [DATA_WIDTH-1:0] slot [FWFT_BUF_DEPTH];
  fwft_idx_t             wr_idx;
  fwft_idx_t             rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FWFT_BUF_DEPTH; i++) begin
        slot[i] <= '0;
      end
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (push) begin
        slot[wr_idx] <= push_data;
        wr_idx       <= wr_idx + fwft_idx_t'(1);
      end
      if (pop) begin
        rd_idx <= rd_idx + fwft_idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + fwft_cnt_t'(1);
        2'b01:   cnt <= cnt - fwft_cnt_t'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = slot[rd_idx];

endmodule

// File: rtl/vfifo_rd_fwft.sv
// FWFT read controller: owns rd_ptr, drives RAM port-B address, streams words out.
// Latency: wr_ptr change to dout_valid is 2 cycles. Backpressure: at most 2 words fetched past the last pop.
// rd_ptr is a plain register so it can be Gray-coded and synchronised outside.
module vfifo_rd_fwft
  import vfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  vfifo_rd_fwft_if.master bus
);

  logic [ADDR_WIDTH:0]   rd_ptr_q;
  logic                  infl_q;
  fwft_cnt_t             cnt;
  logic [DATA_WIDTH-1:0] head;
  logic                  avail;
  logic                  pop;
  logic                  issue;
  logic                  dout_valid;

  // Only equality matters, so a multi-step jump of the synchronised wr_ptr is harmless.
  assign avail      = (bus.wr_ptr != rd_ptr_q);
  assign dout_valid = (cnt != '0);
  assign pop        = dout_valid & bus.dout_ready;

  // Fetch only if the word still has a buffer slot when it lands next cycle.
  assign issue = avail &&
                 (fwft_committed(cnt, infl_q, pop) < fwft_occ_t'(FWFT_BUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      infl_q   <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + (ADDR_WIDTH+1)'(1);
      end
      infl_q <= issue;
    end
  end

  vfifo_fwft_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_q),
    .push_data (bus.q_b),
    .pop       (pop),
    .head      (head),
    .cnt       (cnt)
  );

  assign bus.rd_ptr     = rd_ptr_q;
  assign bus.adr_b      = rd_ptr_q[ADDR_WIDTH-1:0];
  assign bus.dout       = head;
  assign bus.dout_valid = dout_valid;
  assign bus.empty      = !avail && !infl_q && (cnt == '0);

endmodule
